// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter and related round-robin arbiters.
// Widths are derived from parameters via constant functions so every user sizes itself.
package reg_write_arbiter_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int IDX_W     = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;
    localparam int RR_MAX    = 32;

    // Index width that never collapses to zero bits for single-entry arbiters.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reference round-robin pick: scan from ptr upward with wrap, return one-hot grant.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input int n,
                                                  input int ptr);
        logic [RR_MAX-1:0] g;
        int idx;
        logic found;
        g     = '0;
        found = 1'b0;
        for (int off = 0; off < RR_MAX; off++) begin
            if (off < n && !found) begin
                idx = (ptr + off) % n;
                if (req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick_comb.sv
// Round-robin pick: rotate requests by ptr, priority-encode lowest, unrotate to an index.
// Latency: purely combinational.
// Backpressure: none; grant is a pure function of req and ptr.
module rr_pick_comb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  enc;
    logic [IW:0]    sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
    end

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        enc = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IW'(i);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, enc} + {1'b0, ptr};
        if (int'(sum) >= N) begin
            sum = sum - (IW+1)'(N);
        end
        idx = sum[IW-1:0];
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin shared-register writer with optional bounded lock-based burst ownership.
// Latency: gnt is combinational; q/owner/wr_valid update at the grant edge (visible next cycle).
// Backpressure: requesters hold req/wdata until they see gnt; ungranted requests simply wait.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            lock,
    input  logic [N_REQ*WIDTH-1:0]      wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [WIDTH-1:0]            q,
    output logic [idx_width(N_REQ)-1:0] owner,
    output logic                        wr_valid
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = idx_width(LOCK_MAX);

    logic [IW-1:0]    ptr;
    logic [CW-1:0]    lock_cnt;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] sel_data;
    logic [IW-1:0]    next_idx;
    logic [CW-1:0]    eff_cnt;
    logic             keep;

    rr_pick_comb #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gnt = reset ? pick_gnt : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // The lock count only carries over while the same requester keeps winning.
    always_comb begin
        eff_cnt  = (pick_idx == owner) ? lock_cnt : '0;
        keep     = lock[pick_idx] && (int'(eff_cnt) < LOCK_MAX - 1);
        next_idx = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock_cnt <= '0;
            q        <= '0;
            owner    <= '0;
            wr_valid <= 1'b0;
        end else if (pick_any) begin
            q        <= sel_data;
            owner    <= pick_idx;
            wr_valid <= 1'b1;
            if (keep) begin
                ptr      <= pick_idx;
                lock_cnt <= eff_cnt + CW'(1);
            end else begin
                ptr      <= next_idx;
                lock_cnt <= '0;
            end
        end else begin
            wr_valid <= 1'b0;
            lock_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized checks of reg_write_arbiter with N_REQ=4, WIDTH=8, LOCK_MAX=4.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LM = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           wr_valid;

    int checks = 0;
    int fails  = 0;

    int          m_ptr, m_cnt, m_owner, g, eff;
    logic [W-1:0] m_q;
    logic        m_valid;
    logic [N-1:0] pend;
    int          wait_c [N];
    logic [N-1:0] exp_g;

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .LOCK_MAX(LM)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .owner    (owner),
        .wr_valid (wr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int off = 0; off < N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    initial begin
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_q", q, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_owner", owner, 0);
        reset = 1'b1;

        // Idle requests: nothing moves.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_gnt", gnt, 0);
            chk("idle_q", q, 0);
            chk("idle_wr_valid", wr_valid, 0);
            chk("idle_owner", owner, 0);
        end

        // All requesting, unlocked: grants rotate 0,1,2,3,0.
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rot_gnt", gnt, 32'(1) << (k % 4));
            tick();
            chk("rot_q", q, 8'h10 + 8'(k % 4));
            chk("rot_wr_valid", wr_valid, 1);
            chk("rot_owner", owner, k % 4);
        end

        // Grant 3 so the pointer comes back to 0.
        req = 4'b1000;
        #1;
        chk("to0_gnt", gnt, 4'b1000);
        tick();
        chk("to0_q", q, 8'h13);

        // Lock on requester 0: four grants, then 1 once, then 0 again.
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("lock_gnt", gnt, (k == 4) ? 4'b0010 : 4'b0001);
            tick();
            chk("lock_q", q, (k == 4) ? 8'h11 : 8'h10);
        end

        // Move ptr to 3, then wrap: req only 0.
        lock = 4'b0000;
        req  = 4'b0100;
        #1;
        chk("wrap_pre_gnt", gnt, 4'b0100);
        tick();
        req = 4'b0001;
        #1;
        chk("wrap_gnt", gnt, 4'b0001);
        tick();
        chk("wrap_q", q, 8'h10);
        chk("wrap_owner", owner, 0);
        req = 4'b0011;
        #1;
        chk("wrap_next_ptr_gnt", gnt, 4'b0010);
        tick();

        // Reset in the middle of a locked burst.
        req  = 4'b0001;
        lock = 4'b0001;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_wr_valid", wr_valid, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_owner", owner, 0);
        lock  = 4'b0000;
        req   = 4'b1010;
        reset = 1'b1;
        #1;
        chk("postrst_gnt", gnt, 4'b0010);
        tick();
        chk("postrst_q", q, 8'h11);
        chk("postrst_owner", owner, 1);

        // Randomized traffic against a scan-based model.
        reset = 1'b0;
        #2;
        reset   = 1'b1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_owner = 0;
        m_q     = '0;
        m_valid = 1'b0;
        pend    = '0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    req[i]          = 1'($urandom_range(0, 1));
                    wdata[i*W +: W] = 8'($urandom_range(0, 255));
                end
            end
            lock = 4'($urandom_range(0, 15));
            #1;
            g     = model_pick(req, m_ptr);
            exp_g = (g < 0) ? 4'b0000 : 4'(1 << g);
            chk("rnd_gnt", gnt, exp_g);
            for (int i = 0; i < N; i++) begin
                pend[i] = req[i] && (i != g);
                wait_c[i] = pend[i] ? wait_c[i] + 1 : 0;
                if (pend[i]) chk("rnd_wait_bound", (wait_c[i] <= N * LM), 1);
            end
            if (g >= 0) begin
                eff     = (g == m_owner) ? m_cnt : 0;
                m_q     = wdata[g*W +: W];
                m_owner = g;
                m_valid = 1'b1;
                if (lock[g] && eff < LM - 1) begin
                    m_ptr = g;
                    m_cnt = eff + 1;
                end else begin
                    m_ptr = (g + 1) % N;
                    m_cnt = 0;
                end
            end else begin
                m_valid = 1'b0;
                m_cnt   = 0;
            end
            tick();
            chk("rnd_q", q, m_q);
            chk("rnd_wr_valid", wr_valid, m_valid);
            chk("rnd_owner", owner, m_owner);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
